// File: rtl/reg_wb_queue_if.sv
// Write-back queue bus: execute-stage write requests in, regfile write port and hazard status out.
// Optional forwarding signals appear only when REGWB_FWD_EN is defined.
interface reg_wb_queue_if;
    logic        upd_valid;
    logic [2:0]  upd_reg;
    logic [15:0] upd_data;
    logic        res_valid;
    logic [2:0]  res_reg;
    logic [15:0] res_data;
    logic        in_ready;
    logic        wr_hold;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic [7:0]  pending;
    logic        idle;
`ifdef REGWB_FWD_EN
    logic [2:0]  fwd_sel;
    logic        fwd_hit;
    logic [15:0] fwd_data;
`endif

    modport master (
        output upd_valid, upd_reg, upd_data, res_valid, res_reg, res_data, wr_hold,
`ifdef REGWB_FWD_EN
        output fwd_sel,
        input  fwd_hit, fwd_data,
`endif
        input  in_ready, wr_en, wr_sel, wr_data, pending, idle
    );

    modport slave (
        input  upd_valid, upd_reg, upd_data, res_valid, res_reg, res_data, wr_hold,
`ifdef REGWB_FWD_EN
        input  fwd_sel,
        output fwd_hit, fwd_data,
`endif
        output in_ready, wr_en, wr_sel, wr_data, pending, idle
    );
endinterface

// File: rtl/reg_wb_queue.sv
// PDP-11 write-back queue: serializes side-effect and result writes onto one regfile port.
// Define REGWB_FWD_EN to add newest-entry forwarding (fwd_sel/fwd_hit/fwd_data).
module reg_wb_queue #(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    reg_wb_queue_if.slave wb
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [2:0]    reg_q  [DEPTH];
    logic [15:0]   data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          in_ready_s;
    logic          push_upd_s;
    logic          push_res_s;
    logic          pop_s;
    logic [PW-1:0] res_ptr_s;
    logic [7:0]    pending_s;

    // Handshake and pointer/count next-state
    always_comb begin
        in_ready_s = (count_q <= CW'(DEPTH - 2));
        push_upd_s = in_ready_s && wb.upd_valid;
        push_res_s = in_ready_s && wb.res_valid;
        pop_s      = (count_q != {CW{1'b0}}) && !wb.wr_hold;
        res_ptr_s  = push_upd_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        wr_ptr_d   = wr_ptr_q + PW'(push_upd_s) + PW'(push_res_s);
        rd_ptr_d   = rd_ptr_q + PW'(pop_s);
        count_d    = count_q + CW'(push_upd_s) + CW'(push_res_s) - CW'(pop_s);
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents beyond count are don't-care, so no reset is needed
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push_upd_s) begin
                reg_q[wr_ptr_q]  <= wb.upd_reg;
                data_q[wr_ptr_q] <= wb.upd_data;
            end
            if (push_res_s) begin
                reg_q[res_ptr_s]  <= wb.res_reg;
                data_q[res_ptr_s] <= wb.res_data;
            end
        end
    end

    // Pending mask (and forwarding) scan: oldest to newest so the newest match wins
    always_comb begin
        pending_s = 8'h00;
`ifdef REGWB_FWD_EN
        wb.fwd_hit  = 1'b0;
        wb.fwd_data = 16'h0000;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                pending_s[reg_q[rd_ptr_q + PW'(i)]] = 1'b1;
`ifdef REGWB_FWD_EN
                if (reg_q[rd_ptr_q + PW'(i)] == wb.fwd_sel) begin
                    wb.fwd_hit  = 1'b1;
                    wb.fwd_data = data_q[rd_ptr_q + PW'(i)];
                end
`endif
            end
        end
    end

    assign wb.in_ready = in_ready_s;
    assign wb.wr_en    = pop_s;
    assign wb.wr_sel   = (count_q != {CW{1'b0}}) ? reg_q[rd_ptr_q]  : 3'd0;
    assign wb.wr_data  = (count_q != {CW{1'b0}}) ? data_q[rd_ptr_q] : 16'h0000;
    assign wb.pending  = pending_s;
    assign wb.idle     = (count_q == {CW{1'b0}});
endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed vector bench for reg_wb_queue (DEPTH=4): table rows plus streaming and forwarding sequences.
module tb_reg_wb_queue;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    reg_wb_queue_if bus();

    reg_wb_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        uv;
        logic [2:0]  ur;
        logic [15:0] ud;
        logic        rv;
        logic [2:0]  rr;
        logic [15:0] rd;
        logic        hold;
        logic        e_en;
        logic [2:0]  e_sel;
        logic [15:0] e_data;
        logic [7:0]  e_pend;
        logic        e_idle;
        logic        e_rdy;
    } vec_t;

    vec_t vt[23];

    function automatic vec_t mk(logic rst, logic uv, logic [2:0] ur, logic [15:0] ud,
                                logic rv, logic [2:0] rr, logic [15:0] rd, logic hold,
                                logic e_en, logic [2:0] e_sel, logic [15:0] e_data,
                                logic [7:0] e_pend, logic e_idle, logic e_rdy);
        vec_t v;
        v.rst = rst; v.uv = uv; v.ur = ur; v.ud = ud;
        v.rv = rv; v.rr = rr; v.rd = rd; v.hold = hold;
        v.e_en = e_en; v.e_sel = e_sel; v.e_data = e_data;
        v.e_pend = e_pend; v.e_idle = e_idle; v.e_rdy = e_rdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [2:0] sel,
                           input logic [15:0] data, input logic [7:0] pend,
                           input logic idl, input logic rdy);
        chk({tag, ".wr_en"},    {15'd0, bus.wr_en},    {15'd0, en});
        chk({tag, ".wr_sel"},   {13'd0, bus.wr_sel},   {13'd0, sel});
        chk({tag, ".wr_data"},  bus.wr_data,           data);
        chk({tag, ".pending"},  {8'd0, bus.pending},   {8'd0, pend});
        chk({tag, ".idle"},     {15'd0, bus.idle},     {15'd0, idl});
        chk({tag, ".in_ready"}, {15'd0, bus.in_ready}, {15'd0, rdy});
    endtask

    task automatic drive(input logic uv, input logic [2:0] ur, input logic [15:0] ud,
                         input logic rv, input logic [2:0] rr, input logic [15:0] rd,
                         input logic hold);
        bus.upd_valid = uv;
        bus.upd_reg   = ur;
        bus.upd_data  = ud;
        bus.res_valid = rv;
        bus.res_reg   = rr;
        bus.res_data  = rd;
        bus.wr_hold   = hold;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
`ifdef REGWB_FWD_EN
        bus.fwd_sel = 3'd0;
`endif
        // Expectations describe outputs before the row's clock edge.
        //          rst  uv   ur    ud        rv   rr    rd        hold   en   sel   data      pend    idle rdy
        vt[0]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b0,3'd0,16'h0000,8'h00,1'b1,1'b1);
        vt[1]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b1,3'd3,16'h1234,1'b0,  1'b0,3'd0,16'h0000,8'h00,1'b1,1'b1);
        vt[2]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b1,3'd3,16'h1234,8'h08,1'b0,1'b1);
        vt[3]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b0,3'd0,16'h0000,8'h00,1'b1,1'b1);
        vt[4]  = mk(1'b0,1'b1,3'd2,16'h0102,1'b1,3'd2,16'hBEEF,1'b0,  1'b0,3'd0,16'h0000,8'h00,1'b1,1'b1);
        vt[5]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b1,3'd2,16'h0102,8'h04,1'b0,1'b1);
        vt[6]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b1,3'd2,16'hBEEF,8'h04,1'b0,1'b1);
        vt[7]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b0,3'd0,16'h0000,8'h00,1'b1,1'b1);
        vt[8]  = mk(1'b0,1'b1,3'd1,16'h1111,1'b1,3'd4,16'h4444,1'b1,  1'b0,3'd0,16'h0000,8'h00,1'b1,1'b1);
        vt[9]  = mk(1'b0,1'b1,3'd5,16'h5555,1'b1,3'd6,16'h6666,1'b1,  1'b0,3'd1,16'h1111,8'h12,1'b0,1'b1);
        vt[10] = mk(1'b0,1'b1,3'd0,16'hAAAA,1'b1,3'd7,16'h7777,1'b1,  1'b0,3'd1,16'h1111,8'h72,1'b0,1'b0);
        vt[11] = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b1,3'd1,16'h1111,8'h72,1'b0,1'b0);
        vt[12] = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b1,3'd4,16'h4444,8'h70,1'b0,1'b0);
        vt[13] = mk(1'b0,1'b1,3'd3,16'h3333,1'b0,3'd0,16'h0000,1'b0,  1'b1,3'd5,16'h5555,8'h60,1'b0,1'b1);
        vt[14] = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b1,3'd6,16'h6666,8'h48,1'b0,1'b1);
        vt[15] = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b1,3'd3,16'h3333,8'h08,1'b0,1'b1);
        vt[16] = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b0,3'd0,16'h0000,8'h00,1'b1,1'b1);
        vt[17] = mk(1'b0,1'b1,3'd1,16'h0001,1'b1,3'd2,16'h0002,1'b1,  1'b0,3'd0,16'h0000,8'h00,1'b1,1'b1);
        vt[18] = mk(1'b0,1'b0,3'd0,16'h0000,1'b1,3'd3,16'h0003,1'b1,  1'b0,3'd1,16'h0001,8'h06,1'b0,1'b1);
        vt[19] = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b1,3'd1,16'h0001,8'h0E,1'b0,1'b0);
        vt[20] = mk(1'b1,1'b0,3'd0,16'h0000,1'b1,3'd4,16'h4444,1'b0,  1'b1,3'd2,16'h0002,8'h0C,1'b0,1'b1);
        vt[21] = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b0,3'd0,16'h0000,8'h00,1'b1,1'b1);
        vt[22] = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,  1'b0,3'd0,16'h0000,8'h00,1'b1,1'b1);

        repeat (2) @(posedge clk);

        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            reset = vt[k].rst;
            drive(vt[k].uv, vt[k].ur, vt[k].ud, vt[k].rv, vt[k].rr, vt[k].rd, vt[k].hold);
            #1;
            chk_out($sformatf("row%0d", k), vt[k].e_en, vt[k].e_sel, vt[k].e_data,
                    vt[k].e_pend, vt[k].e_idle, vt[k].e_rdy);
        end

        // Streaming: one push per cycle with concurrent drain, pointers wrap several times
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            reset = 1'b0;
            drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'(i % 8), 16'h0100 + 16'(i), 1'b0);
            #1;
            if (i > 0) begin
                chk($sformatf("stream%0d.wr_en", i),   {15'd0, bus.wr_en},  16'h0001);
                chk($sformatf("stream%0d.wr_sel", i),  {13'd0, bus.wr_sel}, 16'((i - 1) % 8));
                chk($sformatf("stream%0d.wr_data", i), bus.wr_data,         16'h0100 + 16'(i - 1));
            end
        end
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
        #1;
        chk_out("stream_last", 1'b1, 3'd1, 16'h0109, 8'h02, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk_out("stream_done", 1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 1'b1);

`ifdef REGWB_FWD_EN
        // Forwarding: two R5 entries held in the queue, newest must win
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h0011, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h0022, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1);
        bus.fwd_sel = 3'd5;
        #1;
        chk("fwd5.hit",  {15'd0, bus.fwd_hit}, 16'h0001);
        chk("fwd5.data", bus.fwd_data,         16'h0022);
        bus.fwd_sel = 3'd4;
        #1;
        chk("fwd4.hit",  {15'd0, bus.fwd_hit}, 16'h0000);
        chk("fwd4.data", bus.fwd_data,         16'h0000);
        @(negedge clk);
        bus.wr_hold = 1'b0;
        #1;
        chk_out("fwd_drain0", 1'b1, 3'd5, 16'h0011, 8'h20, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk_out("fwd_drain1", 1'b1, 3'd5, 16'h0022, 8'h20, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk_out("fwd_done", 1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Write-back side of the PDP-11 datapath. Collects register write requests from the execute stage and serializes them onto the single register-file write port (we / selb / w).
- Two request sources per cycle:
  - side-effect update (autoincrement/autodecrement result), and
  - instruction result.
- Both are queued in a small FIFO and drained one per cycle.
- Exports a pending-register mask so the decoder can stall on read-after-write hazards.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- upd_valid  in  1  side-effect write request this cycle
- upd_reg  in  3  side-effect target register
- upd_data  in  16  side-effect value
- res_valid  in  1  result write request this cycle
- res_reg  in  3  result target register
- res_data  in  16  result value
- in_ready  out  1  queue can accept up to two requests this cycle
- wr_hold  in  1  register-file write port busy; suppresses drain
- wr_en  out  1  to regfile we
- wr_sel  out  3  to regfile selb
- wr_data  out  16  to regfile w
- pending  out  8  bit i set when any queued entry targets Ri
- idle  out  1  queue empty

Behaviour:
- Storage: DEPTH entries of {reg[2:0], data[15:0]}, read/write pointers, count 0..DEPTH.
- in_ready = (count <= DEPTH-2). It is computed from the registered count only; it does not look ahead at a same-cycle pop.
- Push:
  - At a clk edge with in_ready=1, every valid request is enqueued.
  - When both are valid, upd is enqueued first and res second, matching instruction order.
  - Requests presented while in_ready=0 are ignored. The producer must hold them until accepted.
- Drain:
  - wr_en = (count != 0) && !wr_hold.
  - wr_sel/wr_data = head entry when count != 0, otherwise 0.
  - On a clk edge with wr_en=1 the head is popped. The regfile commits the same edge.
- Latency: a request accepted at edge N appears on wr_* during cycle N+1 and is committed at edge N+1, if not held.
- Throughput: one write per cycle. Two requests per cycle are sustainable only in bursts.
- Push and pop on the same edge are allowed. count_next = count + pushes - pop.
- Same register in upd and res:
  - Both are enqueued and written in order, so res is the final value.
  - pending stays set until the last matching entry drains.
- pending is combinational: the OR of one-hot(reg) over all valid entries. Entries pushed this edge appear in pending the next cycle.
- idle = (count == 0).
- wr_hold=1: wr_en=0 and nothing is popped. Pushes continue while in_ready=1.
- Full: count=DEPTH-1 or DEPTH gives in_ready=0. Pointers wrap modulo DEPTH.
- Reset:
  - count=0, both pointers=0, all queued entries discarded.
  - Outputs: wr_en=0, wr_sel=0, wr_data=0, pending=0, idle=1, in_ready=1.
  - Reset overrides a same-edge push or pop.
- R7 gets no special treatment; the regfile clears R7 on its own reset.

Optional Feature:
- Macro REGWB_FWD_EN.
- When defined, three ports are added:
  - fwd_sel in 3
  - fwd_hit out 1
  - fwd_data out 16
- fwd_hit=1 when any valid entry targets fwd_sel. fwd_data is the data of the newest such entry (the one nearest the tail).
- Both outputs are combinational and 0 on no hit.
- The datapath uses this to read queued values without stalling.
- When undefined, these ports and their logic are absent. Hazards are then handled only through pending.

Test Plan:
1. Reset, then idle cycles -> wr_en=0, pending=8'h00, idle=1, in_ready=1.
2. Single res R3=16'h1234 at edge N -> cycle N+1: wr_en=1, wr_sel=3, wr_data=16'h1234, pending=8'h08; cycle N+2: idle=1, pending=0.
3. upd R2=16'h0102 and res R2=16'hBEEF on the same edge -> R2 written with 16'h0102, then 16'hBEEF on consecutive cycles; pending[2] clears only after the second write.
4. DEPTH=4, wr_hold=1, two dual pushes -> count=4, in_ready=0. A third push with distinct values is dropped. Release wr_hold -> exactly 4 writes drain in order and no dropped value appears.
5. Three entries queued, reset asserted mid-drain -> next cycle wr_en=0, pending=0, idle=1. Nothing further is written.
6. (REGWB_FWD_EN) Queue R5=16'h0011 then R5=16'h0022, hold drain, fwd_sel=5 -> fwd_hit=1, fwd_data=16'h0022. fwd_sel=4 -> fwd_hit=0, fwd_data=0.
